// File: rtl/modulo_varredura_matriz.sv
// Row scanner for a 7x5 LED matrix with a double-buffered frame store.
// One row is lit for DIV cycles, then all rows are dark for BLANK cycles.
// Writes always go to the back buffer. Buffers exchange only at a frame
// boundary or while idle, so a displayed frame is never torn.
module modulo_varredura_matriz #(
    parameter int DIV   = 1000,
    parameter int BLANK = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [4:0] wr_data,
    input  logic       swap_req,
    output logic       swap_ack,
    output logic [2:0] mdl,
    output logic [6:0] row_n,
    output logic [4:0] col,
    output logic       frame_tick
);

    // The prescaler is at least 16 bits and grows when DIV or BLANK needs more.
    localparam int CW = ($clog2(DIV + BLANK) > 16) ? $clog2(DIV + BLANK) : 16;
    localparam logic [CW-1:0] ON_LAST    = CW'(DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ON,
        ST_BLANK
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      mdl_q;
    logic [6:0]      rowN_q;
    logic [4:0]      col_q;
    logic            swapAck_q;
    logic            frameTick_q;
    logic            sel_q;
    logic            sel_d;
    logic [4:0]      frameBuf_q [2][7];
    logic [4:0]      frameBuf_d [2][7];
    logic [4:0]      front_d [7];
    logic            rowEnd;
    logic            frameEnd;
    logic            swapNow;
    logic [2:0]      mdlNext;

    // Active-low one-hot enable for a given row.
    function automatic logic [6:0] rowSel(input logic [2:0] idx);
        return ~(7'b000_0001 << idx);
    endfunction

    // Decide where the current row ends and whether the buffers swap at this edge.
    // An idle swap is blocked while the ack is still high, so a requester
    // that drops swap_req only after seeing the ack gets exactly one swap.
    always_comb begin
        rowEnd   = (state_q == ST_BLANK) && (cnt_q == BLANK_LAST);
        frameEnd = rowEnd && (mdl_q == 3'd6);
        swapNow  = swap_req && (frameEnd || ((state_q == ST_IDLE) && !swapAck_q));
        sel_d    = sel_q ^ swapNow;
        mdlNext  = (mdl_q == 3'd6) ? 3'd0 : mdl_q + 3'd1;
    end

    // Next buffer contents: a write lands in the pre-swap back buffer.
    // The front view is taken after any swap, so data written at a swap
    // edge is displayed straight away.
    always_comb begin
        frameBuf_d = frameBuf_q;
        if (wr_en && (wr_addr != 3'd7)) begin
            frameBuf_d[~sel_q][wr_addr] = wr_data;
        end
        for (int i = 0; i < 7; i++) begin
            front_d[i] = frameBuf_d[sel_d][i];
        end
    end

    // Frame store and front/back select.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < 7; r++) begin
                    frameBuf_q[b][r] <= 5'd0;
                end
            end
        end else begin
            sel_q      <= sel_d;
            frameBuf_q <= frameBuf_d;
        end
    end

    // Scan FSM. The row, column and pulse outputs are all registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            mdl_q       <= 3'd0;
            rowN_q      <= 7'h7F;
            col_q       <= 5'd0;
            swapAck_q   <= 1'b0;
            frameTick_q <= 1'b0;
        end else begin
            swapAck_q   <= swapNow;
            frameTick_q <= frameEnd;
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    mdl_q <= 3'd0;
                    if (en) begin
                        state_q <= ST_ON;
                        rowN_q  <= rowSel(3'd0);
                        col_q   <= front_d[0];
                    end else begin
                        rowN_q  <= 7'h7F;
                        col_q   <= 5'd0;
                    end
                end
                ST_ON: begin
                    if (cnt_q == ON_LAST) begin
                        state_q <= ST_BLANK;
                        cnt_q   <= '0;
                        rowN_q  <= 7'h7F;
                        col_q   <= 5'd0;
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
                        rowN_q  <= rowSel(mdl_q);
                        col_q   <= front_d[mdl_q];
                    end
                end
                ST_BLANK: begin
                    if (rowEnd) begin
                        cnt_q <= '0;
                        if (en) begin
                            state_q <= ST_ON;
                            mdl_q   <= mdlNext;
                            rowN_q  <= rowSel(mdlNext);
                            col_q   <= front_d[mdlNext];
                        end else begin
                            state_q <= ST_IDLE;
                            mdl_q   <= 3'd0;
                            rowN_q  <= 7'h7F;
                            col_q   <= 5'd0;
                        end
                    end else begin
                        cnt_q  <= cnt_q + 1'b1;
                        rowN_q <= 7'h7F;
                        col_q  <= 5'd0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    mdl_q   <= 3'd0;
                    rowN_q  <= 7'h7F;
                    col_q   <= 5'd0;
                end
            endcase
        end
    end

    assign swap_ack   = swapAck_q;
    assign mdl        = mdl_q;
    assign row_n      = rowN_q;
    assign col        = col_q;
    assign frame_tick = frameTick_q;

endmodule

// File: doc/modulo_varredura_matriz.md
MODULO_VARREDURA_MATRIZ -- requirements
Module: modulo_varredura_matriz

Interface
Parameters:
- REQ-001 The block SHALL have parameter DIV, default 1000: number of clk cycles a row is lit; DIV SHALL be at least 1.
- REQ-002 The block SHALL have parameter BLANK, default 4: number of dead-time clk cycles between rows; BLANK SHALL be at least 1.

Ports:
- REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
- REQ-004 reset  in  1  synchronous, active-high reset.
- REQ-005 en  in  1  scan enable.
- REQ-006 wr_en  in  1  write strobe into the back frame buffer.
- REQ-007 wr_addr  in  3  back-buffer row 0..6.
- REQ-008 wr_data  in  5  column pattern for that row; bit 4 is the leftmost column.
- REQ-009 swap_req  in  1  level request to exchange front and back buffers; the requester SHALL hold it until swap_ack.
- REQ-010 swap_ack  out  1  one-cycle pulse marking the swap.
- REQ-011 mdl  out  3  current row index 0..6; it feeds the row-coordinate module.
- REQ-012 row_n  out  7  active-low one-hot row enable.
- REQ-013 col  out  5  column pattern of the current row, taken from the front buffer.
- REQ-014 frame_tick  out  1  one-cycle pulse at the end of each full frame.

Function
- REQ-015 The block SHALL hold two 7x5 buffers: front (displayed) and back (written); a 1-bit select SHALL decide which is front.
- REQ-016 All outputs SHALL be registered.
- REQ-017 The FSM SHALL have three states: IDLE, ON, BLANK. A prescaler counter of at least 16 bits SHALL count cycles within ON and BLANK.
- REQ-018 IDLE: row_n=7'h7F, col=0, mdl=0; en=1 SHALL move the FSM to ON with mdl=0 and counter=0.
- REQ-019 ON: row_n SHALL have only bit mdl low; col SHALL equal front[mdl]; the counter SHALL increment each cycle; at counter==DIV-1 the FSM SHALL go to BLANK with counter=0.
- REQ-020 BLANK: row_n=7'h7F and col=0; at counter==BLANK-1 the FSM SHALL take the row boundary defined in REQ-021 and REQ-022.
- REQ-021 Row boundary with mdl<6: mdl SHALL increment; the FSM SHALL go to ON if en=1, else to IDLE with mdl=0.
- REQ-022 Row boundary with mdl==6: mdl SHALL wrap to 0 and frame_tick SHALL pulse for one cycle; the FSM SHALL go to ON if en=1, else to IDLE.
- REQ-023 en SHALL be sampled only at a row boundary or in IDLE; deasserting en mid-row SHALL let the current row finish ON and BLANK.
- REQ-024 Row period SHALL be DIV+BLANK cycles; frame period SHALL be 7*(DIV+BLANK) cycles while en=1.
- REQ-025 Swap while scanning: swap_req=1 at the mdl==6 row boundary SHALL exchange the buffers there; swap_ack SHALL pulse in the same cycle as frame_tick.
- REQ-026 Swap while scanning, other times: swap_req SHALL NOT take effect at any other row boundary, so rows are never torn.
- REQ-027 Swap in IDLE: swap_req=1 sampled in IDLE SHALL execute the swap at that edge, with swap_ack high in the following cycle.
- REQ-028 swap_ack SHALL NOT re-pulse while swap_req stays high without a new frame end (scanning) or a new cycle (IDLE); the requester drops swap_req on seeing ack.
- REQ-029 Writes: wr_en=1 with wr_addr 0..6 SHALL write wr_data into the back buffer at that edge; wr_addr=7 SHALL be ignored.
- REQ-030 A write and a swap at the same edge SHALL land in the pre-swap back buffer, which becomes front.
- REQ-031 Writes SHALL never alter the front buffer.

Reset
- REQ-032 reset=1 at an edge SHALL force IDLE, mdl=0, row_n=7'h7F, col=0, swap_ack=0, frame_tick=0, counter=0, buffer select=0, and all 14 buffer rows to 0.
- REQ-033 reset SHALL take priority over en, wr_en and swap_req, including mid-ON and mid-BLANK.
- REQ-034 The first active cycle after reset is released SHALL behave as IDLE.

Verification (DIV=4, BLANK=2)
- REQ-035 reset, then en=1 -> next cycle row_n=7'b1111110, mdl=0 for 4 cycles; 7'h7F for 2 cycles; then row_n=7'b1111101, mdl=1.
- REQ-036 en held 84 cycles -> exactly 2 frame_tick pulses, 42 cycles apart; mdl sequence 0..6,0.
- REQ-037 write row 2=5'b10101 while scanning, then swap_req=1 -> swap_ack coincides with the next frame_tick; afterwards col=5'b10101 whenever mdl=2 in ON; col=0 before the swap.
- REQ-038 en dropped in the 2nd ON cycle of row 3 -> row 3 completes 4 ON and 2 BLANK cycles, then IDLE with row_n=7'h7F, mdl=0; no frame_tick.
- REQ-039 reset in ON of row 4 -> next cycle row_n=7'h7F, col=0, mdl=0; after en=1 and a swap, all rows show col=0.
- REQ-040 wr_en=1, wr_addr=7, wr_data=5'h1F, then swap in IDLE -> swap_ack pulses once; all rows show col=0.
